// File: rtl/apb_uart_rx_fifo_regs.sv
// APB register block for the UART receiver: config registers, RX FIFO, sticky errors, irq.
// Latency: APB reads are zero-wait combinational; a received frame is visible at head/LEVEL one cycle later.
// Backpressure: none. pready is tied high, and frames arriving while the FIFO is full are dropped and flagged as overrun.
module apb_uart_rx_fifo_regs #(
   parameter int FIFO_DEPTH     = 8,
   parameter int BP_W           = 14,
   parameter int RST_BIT_PERIOD = 10,
   parameter int RST_DATA_SIZE  = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            psel,
   input  logic            penable,
   input  logic            pwrite,
   input  logic [3:0]      paddr,
   input  logic [7:0]      pwdata,
   output logic [7:0]      prdata,
   output logic            pready,
   output logic            pslverr,
   input  logic [7:0]      rx_data,
   input  logic            rx_valid,
   input  logic            rx_framing_error,
   output logic [3:0]      data_size,
   output logic [BP_W-1:0] bit_period,
   output logic            irq
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;
   localparam int HW = BP_W - 8;
   localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);
   localparam logic [7:0]    DEPTH_B = 8'(FIFO_DEPTH);

   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [LW-1:0] level;
   logic [1:0]    err_flags;
   logic [LW-1:0] thresh;
   logic [1:0]    irq_en;

   logic       access;
   logic       empty;
   logic       full;
   logic       thr_hit;
   logic       pop;
   logic       push_ok;
   logic       ovr_set;
   logic       fe_set;
   logic       dsize_ok;
   logic       thresh_ok;
   logic       we_err;
   logic       we_bplo;
   logic       we_bphi;
   logic       we_dsize;
   logic       we_irqen;
   logic       we_thresh;
   logic [7:0] bp_hi_rd;

   assign pready    = 1'b1;
   assign access    = psel & penable;
   assign empty     = (level == '0);
   assign full      = (level == DEPTH_L);
   assign thr_hit   = (level >= thresh);
   assign dsize_ok  = (pwdata >= 8'd5) && (pwdata <= 8'd8);
   assign thresh_ok = (pwdata != 8'd0) && (pwdata <= DEPTH_B);

   // A pop in the same cycle frees the slot, so a full FIFO still accepts the frame.
   assign push_ok = rx_valid & ~rx_framing_error & (~full | pop);
   assign ovr_set = rx_valid & ~rx_framing_error & full & ~pop;
   assign fe_set  = rx_valid & rx_framing_error;

   assign irq = (irq_en[0] & thr_hit) | (irq_en[1] & (|err_flags));

   // Zero-extend the upper bit_period slice to a full byte for readback.
   always_comb begin
      bp_hi_rd         = '0;
      bp_hi_rd[HW-1:0] = bit_period[BP_W-1:8];
   end

   // Address decode: read data, error response and per-register write enables.
   always_comb begin
      prdata    = '0;
      pslverr   = 1'b0;
      pop       = 1'b0;
      we_err    = 1'b0;
      we_bplo   = 1'b0;
      we_bphi   = 1'b0;
      we_dsize  = 1'b0;
      we_irqen  = 1'b0;
      we_thresh = 1'b0;
      if (access) begin
         case (paddr)
            4'h0: begin
               if (pwrite) pslverr = 1'b1;
               else        prdata  = {5'b0, thr_hit, full, ~empty};
            end
            4'h1: begin
               if (pwrite) we_err = 1'b1;
               else        prdata = {6'b0, err_flags};
            end
            4'h2: begin
               if (pwrite) we_bplo = 1'b1;
               else        prdata  = bit_period[7:0];
            end
            4'h3: begin
               if (pwrite) we_bphi = 1'b1;
               else        prdata  = bp_hi_rd;
            end
            4'h4: begin
               if (pwrite) begin
                  if (dsize_ok) we_dsize = 1'b1;
                  else          pslverr  = 1'b1;
               end else begin
                  prdata = {4'b0, data_size};
               end
            end
            4'h5: begin
               if (pwrite) we_irqen = 1'b1;
               else        prdata   = {6'b0, irq_en};
            end
            4'h6: begin
               // Reading an empty FIFO is an error response, not an underflow flag.
               if (pwrite || empty) begin
                  pslverr = 1'b1;
               end else begin
                  prdata = mem[rd_ptr];
                  pop    = 1'b1;
               end
            end
            4'h7: begin
               if (pwrite) begin
                  if (thresh_ok) we_thresh = 1'b1;
                  else           pslverr   = 1'b1;
               end else begin
                  prdata = 8'(thresh);
               end
            end
            4'h8: begin
               if (pwrite) pslverr = 1'b1;
               else        prdata  = 8'(level);
            end
            default: pslverr = 1'b1;
         endcase
      end
   end

   // Configuration registers, committed at the edge ending a legal write access.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bit_period <= BP_W'(RST_BIT_PERIOD);
         data_size  <= 4'(RST_DATA_SIZE);
         thresh     <= LW'(1);
         irq_en     <= 2'b00;
      end else begin
         if (we_bplo)   bit_period[7:0]      <= pwdata;
         if (we_bphi)   bit_period[BP_W-1:8] <= pwdata[HW-1:0];
         if (we_dsize)  data_size            <= pwdata[3:0];
         if (we_thresh) thresh               <= pwdata[LW-1:0];
         if (we_irqen)  irq_en               <= pwdata[1:0];
      end
   end

   // Sticky error flags: hardware set wins over a same-cycle write-1-to-clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_flags <= 2'b00;
      end else begin
         err_flags <= (err_flags & ~(we_err ? pwdata[1:0] : 2'b00)) | {ovr_set, fe_set};
      end
   end

   // FIFO pointers and occupancy; reset flushes by clearing pointers and level.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop)     rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

   // FIFO storage; contents are don't-care until written, so no reset.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= rx_data;
   end

endmodule

// File: tb/tb_apb_uart_rx_fifo_regs.sv
module tb_apb_uart_rx_fifo_regs;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        psel = 1'b0;
   logic        penable = 1'b0;
   logic        pwrite = 1'b0;
   logic [3:0]  paddr = '0;
   logic [7:0]  pwdata = '0;
   logic [7:0]  prdata;
   logic        pready;
   logic        pslverr;
   logic [7:0]  rx_data = '0;
   logic        rx_valid = 1'b0;
   logic        rx_framing_error = 1'b0;
   logic [3:0]  data_size;
   logic [13:0] bit_period;
   logic        irq;

   int errors = 0;
   int checks = 0;
   logic [7:0] exp_q [$];

   apb_uart_rx_fifo_regs #(
      .FIFO_DEPTH(8), .BP_W(14), .RST_BIT_PERIOD(10), .RST_DATA_SIZE(8)
   ) dut (
      .clk(clk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready),
      .pslverr(pslverr), .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_framing_error(rx_framing_error), .data_size(data_size),
      .bit_period(bit_period), .irq(irq)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       wr;
      logic [3:0] addr;
      logic [7:0] wdata;
      logic [7:0] exp_rdata;
      logic       exp_err;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // One APB transfer; optionally drives an rx frame during the access cycle.
   task automatic apb(input logic wr, input logic [3:0] a, input logic [7:0] wd,
                      input logic rxv, input logic [7:0] rxd, input logic rxfe,
                      output logic [7:0] rd, output logic er);
      @(posedge clk); #1;
      psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd;
      @(posedge clk); #1;
      penable = 1'b1;
      rx_valid = rxv; rx_data = rxd; rx_framing_error = rxfe;
      #3;
      rd = prdata; er = pslverr;
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      rx_valid = 1'b0; rx_framing_error = 1'b0;
   endtask

   task automatic apb_rd(input logic [3:0] a, output logic [7:0] rd, output logic er);
      apb(1'b0, a, 8'h00, 1'b0, 8'h00, 1'b0, rd, er);
   endtask

   task automatic apb_wr(input logic [3:0] a, input logic [7:0] wd, output logic er);
      logic [7:0] d;
      apb(1'b1, a, wd, 1'b0, 8'h00, 1'b0, d, er);
   endtask

   task automatic rx_push(input logic [7:0] d, input logic fe);
      @(posedge clk); #1;
      rx_valid = 1'b1; rx_data = d; rx_framing_error = fe;
      @(posedge clk); #1;
      rx_valid = 1'b0; rx_framing_error = 1'b0;
   endtask

   // Pop the FIFO over APB and compare against the scoreboard head.
   task automatic rd_fifo(input string name);
      logic [7:0] d;
      logic       e;
      apb_rd(4'h6, d, e);
      if (exp_q.size() > 0) begin
         check({name, "_data"}, d, exp_q.pop_front());
         check({name, "_err"}, e, 1'b0);
      end else begin
         check({name, "_empty_data"}, d, 8'h00);
         check({name, "_empty_err"}, e, 1'b1);
      end
   endtask

   task automatic rd_reg(input string name, input logic [3:0] a, input logic [7:0] exp);
      logic [7:0] d;
      logic       e;
      apb_rd(a, d, e);
      check(name, d, exp);
      check({name, "_err"}, e, 1'b0);
   endtask

   initial begin
      vec_t vecs[$];
      logic [7:0] d;
      logic       e;

      vecs.push_back('{1'b0, 4'h2, 8'h00, 8'h0A, 1'b0});
      vecs.push_back('{1'b0, 4'h3, 8'h00, 8'h00, 1'b0});
      vecs.push_back('{1'b0, 4'h4, 8'h00, 8'h08, 1'b0});
      vecs.push_back('{1'b0, 4'h7, 8'h00, 8'h01, 1'b0});
      vecs.push_back('{1'b0, 4'h8, 8'h00, 8'h00, 1'b0});
      vecs.push_back('{1'b0, 4'h0, 8'h00, 8'h00, 1'b0});
      vecs.push_back('{1'b1, 4'h4, 8'h09, 8'h00, 1'b1});
      vecs.push_back('{1'b0, 4'h4, 8'h00, 8'h08, 1'b0});
      vecs.push_back('{1'b1, 4'h4, 8'h04, 8'h00, 1'b1});
      vecs.push_back('{1'b1, 4'h4, 8'h05, 8'h00, 1'b0});
      vecs.push_back('{1'b0, 4'h4, 8'h00, 8'h05, 1'b0});
      vecs.push_back('{1'b1, 4'h4, 8'h08, 8'h00, 1'b0});
      vecs.push_back('{1'b0, 4'hA, 8'h00, 8'h00, 1'b1});
      vecs.push_back('{1'b1, 4'hF, 8'h12, 8'h00, 1'b1});
      vecs.push_back('{1'b1, 4'h0, 8'h01, 8'h00, 1'b1});
      vecs.push_back('{1'b1, 4'h6, 8'h01, 8'h00, 1'b1});
      vecs.push_back('{1'b1, 4'h8, 8'h01, 8'h00, 1'b1});
      vecs.push_back('{1'b1, 4'h7, 8'h00, 8'h00, 1'b1});
      vecs.push_back('{1'b1, 4'h7, 8'h09, 8'h00, 1'b1});
      vecs.push_back('{1'b0, 4'h7, 8'h00, 8'h01, 1'b0});
      vecs.push_back('{1'b1, 4'h7, 8'h08, 8'h00, 1'b0});
      vecs.push_back('{1'b0, 4'h7, 8'h00, 8'h08, 1'b0});
      vecs.push_back('{1'b1, 4'h7, 8'h01, 8'h00, 1'b0});
      vecs.push_back('{1'b1, 4'h3, 8'hFF, 8'h00, 1'b0});
      vecs.push_back('{1'b0, 4'h3, 8'h00, 8'h3F, 1'b0});
      vecs.push_back('{1'b0, 4'h2, 8'h00, 8'h0A, 1'b0});
      vecs.push_back('{1'b1, 4'h3, 8'h00, 8'h00, 1'b0});
      vecs.push_back('{1'b1, 4'h2, 8'h0A, 8'h00, 1'b0});

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_prdata", prdata, 8'h00);
      check("rst_pslverr", pslverr, 1'b0);
      check("rst_irq", irq, 1'b0);
      check("rst_bit_period", bit_period, 14'd10);
      check("rst_data_size", data_size, 4'd8);
      rst = 1'b0;
      @(posedge clk); #1;
      check("pready", pready, 1'b1);
      check("idle_prdata", prdata, 8'h00);

      // Register map vectors
      for (int i = 0; i < vecs.size(); i++) begin
         apb(vecs[i].wr, vecs[i].addr, vecs[i].wdata, 1'b0, 8'h00, 1'b0, d, e);
         if (!vecs[i].wr) check($sformatf("vec%0d_rdata", i), d, vecs[i].exp_rdata);
         check($sformatf("vec%0d_err", i), e, vecs[i].exp_err);
      end
      check("bp_port_after_restore", bit_period, 14'd10);

      // Basic push / pop ordering
      foreach (vecs[i]) begin end
      rx_push(8'h11, 1'b0); exp_q.push_back(8'h11);
      rx_push(8'h22, 1'b0); exp_q.push_back(8'h22);
      rx_push(8'h33, 1'b0); exp_q.push_back(8'h33);
      rd_reg("level3", 4'h8, 8'h03);
      rd_reg("status_3", 4'h0, 8'h05);
      for (int i = 0; i < 3; i++) rd_fifo($sformatf("pop%0d", i));
      rd_reg("level0", 4'h8, 8'h00);
      rd_fifo("pop_empty");
      rd_reg("err_after_empty", 4'h1, 8'h00);

      // Fill, then overrun
      for (int i = 0; i < 8; i++) begin
         rx_push(8'hA0 + 8'(i), 1'b0);
         exp_q.push_back(8'hA0 + 8'(i));
      end
      rd_reg("status_full", 4'h0, 8'h07);
      rx_push(8'h99, 1'b0);
      rd_reg("err_overrun", 4'h1, 8'h02);
      rd_reg("level_full", 4'h8, 8'h08);
      apb_wr(4'h1, 8'h02, e);
      check("w1c_err", e, 1'b0);
      rd_reg("err_cleared", 4'h1, 8'h00);

      // Full FIFO: pop and push in the same cycle
      apb(1'b0, 4'h6, 8'h00, 1'b1, 8'h55, 1'b0, d, e);
      check("simul_pop_data", d, exp_q.pop_front());
      check("simul_pop_err", e, 1'b0);
      exp_q.push_back(8'h55);
      rd_reg("simul_err", 4'h1, 8'h00);
      rd_reg("simul_level", 4'h8, 8'h08);
      for (int i = 0; i < 8; i++) rd_fifo($sformatf("drain%0d", i));
      rd_reg("drained_level", 4'h8, 8'h00);

      // Empty FIFO: pop and push in the same cycle
      apb(1'b0, 4'h6, 8'h00, 1'b1, 8'h66, 1'b0, d, e);
      check("empty_simul_data", d, 8'h00);
      check("empty_simul_err", e, 1'b1);
      exp_q.push_back(8'h66);
      rd_reg("empty_simul_level", 4'h8, 8'h01);
      rd_fifo("empty_simul_pop");

      // Threshold interrupt
      apb_wr(4'h5, 8'h01, e);
      apb_wr(4'h7, 8'h02, e);
      check("thresh2_err", e, 1'b0);
      check("irq_level0", irq, 1'b0);
      rx_push(8'hC1, 1'b0); exp_q.push_back(8'hC1);
      check("irq_level1", irq, 1'b0);
      rx_push(8'hC2, 1'b0); exp_q.push_back(8'hC2);
      check("irq_level2", irq, 1'b1);
      rd_fifo("irq_pop0");
      check("irq_after_pop", irq, 1'b0);
      rd_fifo("irq_pop1");

      // Framing error and error interrupt
      rx_push(8'h77, 1'b1);
      rd_reg("fe_level", 4'h8, 8'h00);
      rd_reg("fe_err", 4'h1, 8'h01);
      check("irq_err_masked", irq, 1'b0);
      apb_wr(4'h5, 8'h03, e);
      check("irq_err_en", irq, 1'b1);
      apb(1'b1, 4'h1, 8'h01, 1'b1, 8'h78, 1'b1, d, e);
      rd_reg("w1c_vs_set", 4'h1, 8'h01);
      apb_wr(4'h1, 8'h01, e);
      rd_reg("fe_cleared", 4'h1, 8'h00);
      check("irq_err_clear", irq, 1'b0);

      // Reset during the access phase of a BP_LO write
      rx_push(8'hD1, 1'b0);
      rx_push(8'hD2, 1'b0);
      @(posedge clk); #1;
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 4'h2; pwdata = 8'h55;
      @(posedge clk); #1;
      penable = 1'b1;
      #2 rst = 1'b1;
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      rst = 1'b0;
      exp_q.delete();
      check("midrst_bit_period", bit_period, 14'd10);
      check("midrst_irq", irq, 1'b0);
      rd_reg("midrst_bplo", 4'h2, 8'h0A);
      rd_reg("midrst_level", 4'h8, 8'h00);
      rd_reg("midrst_irqen", 4'h5, 8'h00);
      rd_reg("midrst_thresh", 4'h7, 8'h01);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
